key_bank: RTL

- Multi-channel push-button front end and parametrised successor of the single-key debouncer.
- Per key: 2-flop synchroniser, debounce, debounced level, press/release pulses, long-press detection and optional auto-repeat.
- Adds a priority-encoded event bus for the control FSM / seg display logic, so consumers need not scan vectors.

---
 rtl/key_pkg.sv | 16 +
 rtl/key_chan.sv | 117 +++++++++++
 rtl/key_bank.sv | 83 ++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared event encodings and width helper for the key_bank push-button front end.
package key_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_RELEASE = 2'd1;
  localparam logic [1:0] EVT_LONG    = 2'd2;
  localparam logic [1:0] EVT_REPEAT  = 2'd3;

  // Bit width needed to index n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_chan.sv
// One push-button channel: 2-flop synchroniser, debouncer and hold/auto-repeat timer.
// Every pulse output is registered and high for exactly one cycle.
module key_chan
  import key_pkg::*;
#(
  parameter int WAIT_BIT      = 8,
  parameter int LONG_CYCLES   = 65536,
  parameter int REPEAT_CYCLES = 8192,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int HOLD_W = clog2_min1(LONG_CYCLES);
  localparam int REP_W  = clog2_min1((REPEAT_CYCLES > 0) ? REPEAT_CYCLES : 1);
  localparam logic [WAIT_BIT-1:0] CNT_LAST  = {WAIT_BIT{1'b1}};
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]    REP_LAST  = REP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  logic                w_key_raw;
  logic                w_differ;
  logic                w_flip;
  logic                r_sync1;
  logic                r_sync2;
  logic                r_level;
  logic [WAIT_BIT-1:0] r_cnt;
  logic [HOLD_W-1:0]   r_hold;
  logic [REP_W-1:0]    r_rep;
  logic                r_long_done;
  logic                r_press;
  logic                r_release;
  logic                r_long;
  logic                r_repeat;

  assign w_key_raw = ACTIVE_LOW ? ~i_key : i_key;
  assign w_differ  = (r_sync2 != r_level);
  assign w_flip    = w_differ && (r_cnt == CNT_LAST);

  // Bring the raw key into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= w_key_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce, hold timing and one-cycle event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level     <= 1'b0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_rep       <= '0;
      r_long_done <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
      r_repeat    <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      if (w_flip) begin
        r_level     <= r_sync2;
        r_cnt       <= '0;
        r_press     <= r_sync2;
        r_release   <= ~r_sync2;
        r_hold      <= '0;
        r_rep       <= '0;
        r_long_done <= 1'b0;
      end else begin
        r_cnt <= w_differ ? (r_cnt + 1'b1) : '0;
        if (!r_level) begin
          r_hold      <= '0;
          r_rep       <= '0;
          r_long_done <= 1'b0;
        end else if (!r_long_done) begin
          // Hold counter stops at its last value once long fires, so it can never wrap.
          if (r_hold == HOLD_LAST) begin
            r_long      <= 1'b1;
            r_long_done <= 1'b1;
            r_rep       <= '0;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end else if (REPEAT_CYCLES > 0) begin
          if (r_rep == REP_LAST) begin
            r_repeat <= 1'b1;
            r_rep    <= '0;
          end else begin
            r_rep <= r_rep + 1'b1;
          end
        end else begin
          r_rep <= '0;
        end
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/key_bank.sv
// Multi-channel push-button front end: N_KEYS key_chan instances plus a
// lowest-index-wins event encoder over their registered pulses.
module key_bank
  import key_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter int WAIT_BIT      = 8,
  parameter int LONG_CYCLES   = 65536,
  parameter int REPEAT_CYCLES = 8192,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_KEYS-1:0]                 key_in,
  output logic [N_KEYS-1:0]                 key_level,
  output logic [N_KEYS-1:0]                 press_pulse,
  output logic [N_KEYS-1:0]                 release_pulse,
  output logic [N_KEYS-1:0]                 long_pulse,
  output logic [N_KEYS-1:0]                 repeat_pulse,
  output logic                              evt_valid,
  output logic [1:0]                        evt_type,
  output logic [clog2_min1(N_KEYS)-1:0]     evt_code,
  output logic                              evt_drop
);

  localparam int CODE_W = clog2_min1(N_KEYS);

  logic [N_KEYS-1:0] w_any;
  logic              w_valid;
  logic [1:0]        w_type;
  logic [CODE_W-1:0] w_code;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_chan #(
      .WAIT_BIT      (WAIT_BIT),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW != 0)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .i_key     (key_in[g]),
      .o_level   (key_level[g]),
      .o_press   (press_pulse[g]),
      .o_release (release_pulse[g]),
      .o_long    (long_pulse[g]),
      .o_repeat  (repeat_pulse[g])
    );
  end

  assign w_any = press_pulse | release_pulse | long_pulse | repeat_pulse;

  // Scan from the top so the lowest-index active channel is the one left standing.
  always_comb begin
    w_valid = 1'b0;
    w_type  = EVT_PRESS;
    w_code  = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (w_any[i]) begin
        w_valid = 1'b1;
        w_code  = CODE_W'(i);
        if (press_pulse[i]) begin
          w_type = EVT_PRESS;
        end else if (release_pulse[i]) begin
          w_type = EVT_RELEASE;
        end else if (long_pulse[i]) begin
          w_type = EVT_LONG;
        end else begin
          w_type = EVT_REPEAT;
        end
      end else begin
        w_valid = w_valid;
      end
    end
  end

  assign evt_valid = w_valid;
  assign evt_type  = w_type;
  assign evt_code  = w_code;
  // Clearing the lowest set bit leaves something only if two or more channels fired.
  assign evt_drop  = |(w_any & (w_any - 1'b1));

endmodule
